// File: rtl/fft_chan_arb.sv
// Two-channel FIFO to FFT frame arbiter: fairly grants whole FFT_POINT-sample frames to ch0/ch1.
// Optional mid-frame starvation counter enabled by defining FFT_ARB_UNDERRUN_CNT_EN.
module fft_chan_arb #(
    parameter int FFT_POINT = 256,
    parameter int RST_HOLD  = 10
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        ch0_fifo_empty,
    input  logic        ch1_fifo_empty,
    output logic        ch0_fifo_rdreq,
    output logic        ch1_fifo_rdreq,
    input  logic [15:0] ch0_fifo_q,
    input  logic [15:0] ch1_fifo_q,
    input  logic        fft_ready,
    output logic        fft_rst_n,
    output logic        fft_valid,
    output logic        fft_sop,
    output logic        fft_eop,
    output logic [15:0] fft_data,
    output logic        fft_chan,
    output logic        frame_done,
    output logic [15:0] underrun_cnt
);

    localparam int CW = $clog2(FFT_POINT + 1);
    localparam logic [CW-1:0] POINT_C = CW'(FFT_POINT);
    localparam logic [CW-1:0] LAST_C  = CW'(FFT_POINT - 1);
    localparam logic [4:0]    HOLD_LAST_C = 5'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_ARB    = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [4:0]      hold_cnt_r;
    logic            fft_rst_n_r;
    logic            chan_r;
    logic            last_r;
    logic [CW-1:0]   issued_r;
    logic [CW-1:0]   vcnt_r;
    logic            valid_r;
    logic            done_r;
    logic [15:0]     data_hold_r;
    logic            rd_s;
    logic            grant_s;
    logic            grant_chan_s;
    logic            sel_empty_s;
    logic            frame_open_s;
    logic            eop_s;
    logic [15:0]     sel_q_s;

    assign sel_empty_s  = chan_r ? ch1_fifo_empty : ch0_fifo_empty;
    assign sel_q_s      = chan_r ? ch1_fifo_q : ch0_fifo_q;
    assign frame_open_s = (issued_r < POINT_C);
    assign eop_s        = valid_r && (vcnt_r == LAST_C);

    // Next-state, grant decision and read request of the granted channel.
    always_comb begin
        state_nxt_s  = state_r;
        grant_s      = 1'b0;
        grant_chan_s = chan_r;
        rd_s         = 1'b0;
        case (state_r)
            ST_HOLD: begin
                if (fft_rst_n_r && fft_ready) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_ARB: begin
                // On a tie the channel not served last wins; last_r resets to ch1.
                if (!ch0_fifo_empty && !ch1_fifo_empty) begin
                    grant_s      = 1'b1;
                    grant_chan_s = ~last_r;
                    state_nxt_s  = ST_STREAM;
                end else if (!ch0_fifo_empty) begin
                    grant_s      = 1'b1;
                    grant_chan_s = 1'b0;
                    state_nxt_s  = ST_STREAM;
                end else if (!ch1_fifo_empty) begin
                    grant_s      = 1'b1;
                    grant_chan_s = 1'b1;
                    state_nxt_s  = ST_STREAM;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_STREAM: begin
                rd_s = !sel_empty_s && fft_ready && frame_open_s;
                if (eop_s) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: begin
                state_nxt_s = ST_HOLD;
            end
        endcase
    end

    assign ch0_fifo_rdreq = rd_s && !chan_r;
    assign ch1_fifo_rdreq = rd_s && chan_r;

    // State, core-reset sequencing, frame counters and output registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_HOLD;
            hold_cnt_r  <= 5'd0;
            fft_rst_n_r <= 1'b0;
            chan_r      <= 1'b0;
            last_r      <= 1'b1;
            issued_r    <= '0;
            vcnt_r      <= '0;
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
            data_hold_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_HOLD && !fft_rst_n_r) begin
                if (hold_cnt_r == HOLD_LAST_C) begin
                    fft_rst_n_r <= 1'b1;
                end else begin
                    hold_cnt_r <= hold_cnt_r + 5'd1;
                end
            end
            if (grant_s) begin
                chan_r <= grant_chan_s;
            end
            if (eop_s) begin
                issued_r <= '0;
                vcnt_r   <= '0;
                last_r   <= chan_r;
            end else begin
                if (rd_s) begin
                    issued_r <= issued_r + CW'(1);
                end
                if (valid_r) begin
                    vcnt_r <= vcnt_r + CW'(1);
                end
            end
            valid_r <= rd_s;
            done_r  <= eop_s;
            if (valid_r) begin
                data_hold_r <= sel_q_s;
            end
        end
    end

    // FIFO data passes straight through on the valid cycle so it lines up with rdreq+1.
    assign fft_rst_n  = fft_rst_n_r;
    assign fft_valid  = valid_r;
    assign fft_sop    = valid_r && (vcnt_r == '0);
    assign fft_eop    = eop_s;
    assign fft_data   = valid_r ? sel_q_s : data_hold_r;
    assign fft_chan   = chan_r;
    assign frame_done = done_r;

`ifdef FFT_ARB_UNDERRUN_CNT_EN
    logic [15:0] underrun_r;

    // Saturating count of streaming cycles starved by an empty granted FIFO.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            underrun_r <= 16'd0;
        end else if (state_r == ST_STREAM && sel_empty_s && fft_ready && frame_open_s
                     && underrun_r != 16'hFFFF) begin
            underrun_r <= underrun_r + 16'd1;
        end
    end

    assign underrun_cnt = underrun_r;
`else
    assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fft_chan_arb.sv
// Self-checking bench for fft_chan_arb: FIFO models, a frame-level scoreboard checked every
// cycle, and directed scenarios with literal expectations.
module tb_fft_chan_arb;

    localparam int N = 256;

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        ch0_fifo_empty = 1'b1;
    logic        ch1_fifo_empty = 1'b1;
    logic        ch0_fifo_rdreq;
    logic        ch1_fifo_rdreq;
    logic [15:0] ch0_fifo_q = 16'd0;
    logic [15:0] ch1_fifo_q = 16'd0;
    logic        fft_ready = 1'b1;
    logic        fft_rst_n;
    logic        fft_valid;
    logic        fft_sop;
    logic        fft_eop;
    logic [15:0] fft_data;
    logic        fft_chan;
    logic        frame_done;
    logic [15:0] underrun_cnt;

    fft_chan_arb #(.FFT_POINT(N), .RST_HOLD(10)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n),
        .ch0_fifo_empty(ch0_fifo_empty), .ch1_fifo_empty(ch1_fifo_empty),
        .ch0_fifo_rdreq(ch0_fifo_rdreq), .ch1_fifo_rdreq(ch1_fifo_rdreq),
        .ch0_fifo_q(ch0_fifo_q), .ch1_fifo_q(ch1_fifo_q),
        .fft_ready(fft_ready), .fft_rst_n(fft_rst_n),
        .fft_valid(fft_valid), .fft_sop(fft_sop), .fft_eop(fft_eop),
        .fft_data(fft_data), .fft_chan(fft_chan), .frame_done(frame_done),
        .underrun_cnt(underrun_cnt)
    );

    always #10 clk_50m = ~clk_50m;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO models (ch0 ramp 0x0000+k, ch1 ramp 0x8000+k) ----------------
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int req0_total = 0, req1_total = 0;
    int push0 = 0, push1 = 0, pop0 = 0, pop1 = 0;
    int stall_at = -1;
    int stall0 = 0;
    int fifo_err = 0;

    initial begin
        bit p0, p1;
        forever begin
            @(posedge clk_50m);
            p0 = ch0_fifo_rdreq;
            p1 = ch1_fifo_rdreq;
            #1;
            if (stall0 > 0) stall0--;
            if (p0) begin
                if (q0.size() > 0) begin
                    ch0_fifo_q = q0.pop_front();
                    pop0++;
                    if (pop0 == stall_at) stall0 = 20;
                end else fifo_err++;
            end
            if (p1) begin
                if (q1.size() > 0) begin
                    ch1_fifo_q = q1.pop_front();
                    pop1++;
                end else fifo_err++;
            end
            while (push0 < req0_total) begin q0.push_back(16'(push0)); push0++; end
            while (push1 < req1_total) begin q1.push_back(16'h8000 + 16'(push1)); push1++; end
            ch0_fifo_empty = (q0.size() == 0) || (stall0 > 0);
            ch1_fifo_empty = (q1.size() == 0);
        end
    end

    // ---------------- frame-level model and per-cycle compare ----------------
    int cyc = 0;
    bit prev_rd = 1'b0, prev_eop = 1'b0;
    bit in_frame = 1'b0, fr_chan = 1'b0, last_srv = 1'b1;
    int issued = 0, vidx = 0, ucnt = 0;
    logic [15:0] last_data = 16'd0;
    int exp_idx[2] = '{0, 0};
    int frames_n = 0;
    int frame_log[$];
    int sop_cyc = 0, last_eop_cyc = -100, gap_run = 0, max_gap = 0, rd_low = 0;
    int last_span = 0, last_maxgap = 0, last_rdlow = 0, done_pulses = 0;

    initial begin
        bit rd0, rd1, e0, e1, exp_rd, ended;
        logic [15:0] exp_d;
        int exp_u;
        forever begin
            @(negedge clk_50m);
            cyc++;
            if (!rst_n) begin
                check("rst_ctrl", int'({fft_rst_n, ch0_fifo_rdreq, ch1_fifo_rdreq, fft_valid,
                                        fft_sop, fft_eop, frame_done, fft_chan}), 0);
                check("rst_data", fft_data, 0);
                check("rst_underrun", underrun_cnt, 0);
                prev_rd = 1'b0; prev_eop = 1'b0; in_frame = 1'b0; last_srv = 1'b1;
                issued = 0; vidx = 0; last_data = 16'd0; ucnt = 0;
                exp_idx[0] = pop0; exp_idx[1] = pop1;
                continue;
            end
            rd0 = ch0_fifo_rdreq; rd1 = ch1_fifo_rdreq;
            e0 = ch0_fifo_empty;  e1 = ch1_fifo_empty;
`ifdef FFT_ARB_UNDERRUN_CNT_EN
            exp_u = ucnt;
`else
            exp_u = 0;
`endif
            check("underrun_cnt", underrun_cnt, exp_u);
            check("valid_after_rd", fft_valid, prev_rd);
            check("frame_done", frame_done, prev_eop);
            check("rd_exclusive", int'(rd0 & rd1), 0);
            if (!fft_rst_n) check("rd_in_hold", int'(rd0 | rd1), 0);
            if (in_frame && issued < N) begin
                exp_rd = !(fr_chan ? e1 : e0) && fft_ready;
                check("rd_granted", int'(fr_chan ? rd1 : rd0), exp_rd);
                check("rd_other", int'(fr_chan ? rd0 : rd1), 0);
                if ((fr_chan ? e1 : e0) && fft_ready && ucnt < 65535) ucnt++;
                if (!(rd0 | rd1)) rd_low++;
                if (rd0 | rd1) issued++;
            end else if (in_frame) begin
                check("rd_after_full", int'(rd0 | rd1), 0);
            end else if (rd0 | rd1) begin
                check("grant_chan", rd1, (!e0 && !e1) ? !last_srv : (e0 ? 1 : 0));
                in_frame = 1'b1; fr_chan = rd1; issued = 1; vidx = 0;
                rd_low = 0; max_gap = 0; gap_run = 0;
            end
            if (in_frame) check("fft_chan", fft_chan, fr_chan);
            ended = 1'b0;
            if (fft_valid) begin
                exp_d = fr_chan ? (16'h8000 + 16'(exp_idx[1])) : 16'(exp_idx[0]);
                check("data", fft_data, exp_d);
                exp_idx[fr_chan]++;
                check("sop", fft_sop, int'(vidx == 0));
                check("eop", fft_eop, int'(vidx == N - 1));
                if (vidx == 0) begin
                    sop_cyc = cyc;
                    check("sop_spacing", int'((cyc - last_eop_cyc) >= 2), 1);
                end
                if (gap_run > max_gap) max_gap = gap_run;
                gap_run = 0;
                last_data = exp_d;
                vidx++;
                if (vidx == N) begin
                    frame_log.push_back(int'(fr_chan));
                    frames_n++;
                    last_srv = fr_chan;
                    last_span = cyc - sop_cyc + 1;
                    last_maxgap = max_gap;
                    last_rdlow = rd_low;
                    last_eop_cyc = cyc;
                    in_frame = 1'b0;
                    vidx = 0;
                    ended = 1'b1;
                end
            end else begin
                check("sop_idle", fft_sop, 0);
                check("eop_idle", fft_eop, 0);
                check("data_hold", fft_data, last_data);
                if (in_frame && vidx > 0) gap_run++;
            end
            if (frame_done) done_pulses++;
            prev_eop = ended;
            prev_rd = rd0 | rd1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_frames(input int target, input int budget, input string name);
        int k = 0;
        while (frames_n < target && k < budget) begin @(posedge clk_50m); k++; end
        check(name, int'(frames_n >= target), 1);
    endtask

    task automatic wait_vidx(input int target, input string name);
        int k = 0;
        while (!(in_frame && vidx >= target) && k < 2000) begin @(posedge clk_50m); k++; end
        check(name, int'(in_frame && vidx >= target), 1);
    endtask

    task automatic count_hold(input string name);
        int k = 0;
        @(negedge clk_50m);
        while (!fft_rst_n && k < 100) begin k++; @(negedge clk_50m); end
        check(name, k, 10);
    endtask

    initial begin
        int u_exp;
        repeat (3) @(posedge clk_50m);
        #2 rst_n = 1'b1;
        count_hold("hold_low_cycles");

        // Single channel, full frame contiguous
        @(posedge clk_50m); #2 req0_total = req0_total + N;
        wait_frames(1, 2000, "t030_timeout");
        if (frames_n >= 1) check("t030_chan", frame_log[0], 0);
        check("t030_span", last_span, N);
        repeat (4) @(posedge clk_50m);
        check("t030_done_pulses", done_pulses, 1);

        // Both channels loaded: frames must alternate
        @(posedge clk_50m); #2;
        req0_total = req0_total + 2 * N;
        req1_total = req1_total + 2 * N;
        wait_frames(5, 6000, "t031_timeout");
        if (frames_n >= 5) begin
            check("t031_f1", frame_log[1], 1);
            check("t031_f2", frame_log[2], 0);
            check("t031_f3", frame_log[3], 1);
            check("t031_f4", frame_log[4], 0);
        end

        // ch0 starves for 20 cycles after its 101st sample
        @(posedge clk_50m); #2;
        stall_at = pop0 + 101;
        req0_total = req0_total + N;
        wait_frames(6, 2000, "t032_timeout");
        if (frames_n >= 6) check("t032_chan", frame_log[5], 0);
        check("t032_gap", last_maxgap, 20);
        check("t032_span", last_span, N + 20);
`ifdef FFT_ARB_UNDERRUN_CNT_EN
        u_exp = 20;
`else
        u_exp = 0;
`endif
        check("t032_underrun", underrun_cnt, u_exp);

        // fft_ready drop for 5 cycles mid-frame on ch1
        @(posedge clk_50m); #2 req1_total = req1_total + N;
        wait_vidx(100, "t033_reach");
        @(posedge clk_50m); #2 fft_ready = 1'b0;
        repeat (5) @(posedge clk_50m);
        #2 fft_ready = 1'b1;
        wait_frames(7, 2000, "t033_timeout");
        if (frames_n >= 7) check("t033_chan", frame_log[6], 1);
        check("t033_rdlow", last_rdlow, 5);
        check("t033_gap", last_maxgap, 5);
        check("t033_span", last_span, N + 5);

        // Reset mid-frame at sample 150
        @(posedge clk_50m); #2 req0_total = req0_total + N;
        wait_vidx(150, "t034_reach");
        @(posedge clk_50m); #2 rst_n = 1'b0;
        @(negedge clk_50m);
        check("t034_rst_valid", fft_valid, 0);
        check("t034_rst_fftrst", fft_rst_n, 0);
        check("t034_rst_data", fft_data, 0);
        repeat (2) @(posedge clk_50m);
        #2;
        req0_total = req0_total + (N - (push0 - pop0));
        req1_total = req1_total + N;
        repeat (2) @(posedge clk_50m);
        #2 rst_n = 1'b1;
        count_hold("t034_hold_low_cycles");
        wait_frames(9, 3000, "t034_timeout");
        if (frames_n >= 9) begin
            check("t034_f7", frame_log[7], 0);
            check("t034_f8", frame_log[8], 1);
        end
        check("t034_span", last_span, N);
        check("fifo_underflow", fifo_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
